// File: rtl/muldiv_hilo_ctrl_if.sv
// Handshake/bus bundle for the HI/LO multiply-divide sequencer.
//   start/op/a/b      : new MULT/MULTU/DIV/DIVU request and its operands
//   hi_we/lo_we/wdata : MTHI/MTLO write port
//   busy/done         : operation in progress / one-cycle commit pulse
//   hi/lo             : architectural HI/LO registers
interface muldiv_hilo_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Shift-add multiply / restoring divide on operand magnitudes, one iteration
// per clock, then a single sign-fix/commit cycle. Also services MTHI/MTLO.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : muldiv_hilo_ctrl_if slave (start/op/a/b, hi_we/lo_we/wdata,
//           busy/done/hi/lo)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; MTHI/MTLO writes accepted here
// S_RUN  | WIDTH iterations of shift-add or restoring divide
// S_FIX  | sign correction, commit HI/LO, pulse done
module muldiv_hilo_ctrl #(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               reset,
   muldiv_hilo_ctrl_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   // Multiply: {partial product (WIDTH+1), multiplier (WIDTH)}.
   // Divide:   {remainder (WIDTH+1), dividend shifting into quotient (WIDTH)}.
   logic [2*WIDTH:0]   acc;
   logic [2*WIDTH:0]   acc_nxt;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               b_zero;
   logic               done_r;

   logic               is_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic               ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;

   always_comb begin
      is_signed = ~bus.op[0];
      a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

      sum    = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
      rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd};
      ge     = (rem_sh >= {1'b0, opnd});

      if (is_div)
         acc_nxt = {(ge ? diff : rem_sh), acc[WIDTH-2:0], ge};
      else
         acc_nxt = {1'b0, (acc[0] ? sum : acc[2*WIDTH:WIDTH]), acc[WIDTH-1:1]};

      prod_fix = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
      // Divide-by-zero: the remainder already equals the dividend (divisor 0
      // subtracts nothing), so only the quotient needs forcing to all ones.
      q_fix    = b_zero ? {WIDTH{1'b1}}
                        : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         count  <= '0;
         acc    <= '0;
         opnd   <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  is_div <= bus.op[1];
                  neg_q  <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  neg_r  <= is_signed & bus.a[WIDTH-1];
                  b_zero <= (bus.b == '0);
                  opnd   <= bus.op[1] ? b_mag : a_mag;
                  acc    <= {{(WIDTH+1){1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                  count  <= '0;
                  state  <= S_RUN;
               end else begin
                  if (bus.hi_we) hi_r <= bus.wdata;
                  if (bus.lo_we) lo_r <= bus.wdata;
               end
            end
            S_RUN: begin
               acc   <= acc_nxt;
               count <= count + 1'b1;
               if (count == LAST) state <= S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  hi_r <= r_fix;
                  lo_r <= q_fix;
               end else begin
                  hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_r <= prod_fix[WIDTH-1:0];
               end
               done_r <= 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (state != S_IDLE);
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
module tb_muldiv_hilo_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   bcnt   = 0;
   int   lat;
   int   ndone;
   time  t_acc;

   always #5 clk = ~clk;

   muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();
   muldiv_hilo_ctrl #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   always @(negedge clk) if (bus.busy) bcnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Present an op on one edge, then scramble operands to prove they were captured.
   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic hw);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      bus.hi_we = hw;   bus.wdata = 32'h0000_FFFF;
      @(posedge clk);
      t_acc = $time;
      bcnt  = 0;
      @(negedge clk);
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.op = ~o;
      bus.a = 32'hA5A5_5A5A; bus.b = 32'h0;
   endtask

   task automatic wait_done(output int l);
      int n = 0;
      while (!bus.done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
      l = int'(($time - t_acc) / 10);
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
      start_op(o, x, y, 1'b0);
      wait_done(lat);
      chk({tag, "_lat"}, 32'(lat), 32'd33);
      chk({tag, "_hi"}, bus.hi, ehi);
      chk({tag, "_lo"}, bus.lo, elo);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      reset = 1'b0;

      // MULTU max*max, with latency, busy width and done pulse width
      start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_done(lat);
      chk("multu_lat", 32'(lat), 32'd33);
      chk("multu_busy_cycles", 32'(bcnt), 32'd33);
      chk("multu_busy_at_done", 32'(bus.busy), 32'd0);
      chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
      chk("multu_lo", bus.lo, 32'h0000_0001);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);

      run("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run("mult_nn",   2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0,         32'd21);
      run("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run("divu",      2'b11, 32'd7,         32'd2,         32'd1,         32'd3);
      run("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
      run("div_by0",   2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run("divu_by0",  2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);

      // start/hi_we/lo_we pulsed mid-op are ignored; hi/lo hold until commit
      start_op(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0);
      repeat (5) @(negedge clk);
      chk("hold_hi", bus.hi, 32'd5);
      chk("hold_lo", bus.lo, 32'hFFFF_FFFF);
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd3;
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_0BAD;
      @(negedge clk);
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      chk("busy_wr_hi", bus.hi, 32'd5);
      wait_done(lat);
      chk("midop_lat", 32'(lat), 32'd33);
      chk("midop_hi", bus.hi, 32'd1);
      chk("midop_lo", bus.lo, 32'd0);

      // reset partway through RUN aborts the op
      start_op(2'b01, 32'd3, 32'd3, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_hi", bus.hi, 32'd0);
      chk("abort_lo", bus.lo, 32'd0);
      reset = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      chk("abort_lo_kept", bus.lo, 32'd0);

      // MTHI / MTLO in IDLE
      bus.hi_we = 1'b1; bus.wdata = 32'h0000_CAFE;
      @(negedge clk);
      bus.hi_we = 1'b0;
      chk("mthi_hi", bus.hi, 32'h0000_CAFE);
      chk("mthi_lo", bus.lo, 32'd0);
      bus.lo_we = 1'b1; bus.wdata = 32'h0000_1234;
      @(negedge clk);
      bus.lo_we = 1'b0;
      chk("mtlo_lo", bus.lo, 32'h0000_1234);
      chk("mtlo_hi", bus.hi, 32'h0000_CAFE);
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_0077;
      @(negedge clk);
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      chk("both_hi", bus.hi, 32'h0000_0077);
      chk("both_lo", bus.lo, 32'h0000_0077);

      // start and hi_we together: start wins, hi not written
      start_op(2'b01, 32'd6, 32'd7, 1'b1);
      chk("start_wins_hi", bus.hi, 32'h0000_0077);
      chk("start_wins_busy", 32'(bus.busy), 32'd1);
      wait_done(lat);
      chk("start_wins_lat", 32'(lat), 32'd33);
      chk("start_wins_rhi", bus.hi, 32'd0);
      chk("start_wins_rlo", bus.lo, 32'd42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
